// File: rtl/fft_mag_frame_reader_if.sv
// Signal bundle between the FFT output stream / Bus2IP register decode and the frame reader.
// The slave modport is the frame reader; the master modport is whoever drives it.
interface fft_mag_frame_reader_if #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned ADDR_W = 9
);
  logic [2*DATA_W-1:0] s_axis_data_tdata;
  logic                s_axis_data_tvalid;
  logic                s_axis_data_tlast;
  logic                s_axis_data_tready;
  logic [31:0]         Bus2IP_Data;
  logic                Bus2IP_WrCE;
  logic                mem_select;
  logic [ADDR_W-1:0]   mem_address;
  logic                mem_read_enable;
  logic [31:0]         mem_ip2bus_data;
  logic                frame_done;

  modport slave (
    input  s_axis_data_tdata, s_axis_data_tvalid, s_axis_data_tlast,
    input  Bus2IP_Data, Bus2IP_WrCE, mem_select, mem_address, mem_read_enable,
    output s_axis_data_tready, mem_ip2bus_data, frame_done
  );

  modport master (
    output s_axis_data_tdata, s_axis_data_tvalid, s_axis_data_tlast,
    output Bus2IP_Data, Bus2IP_WrCE, mem_select, mem_address, mem_read_enable,
    input  s_axis_data_tready, mem_ip2bus_data, frame_done
  );
endinterface

// File: rtl/fft_mag_frame_reader.sv
// Captures one frame of FFT bins as saturated |X|^2 into a local RAM and exposes the frame,
// capture status and counters through the Bus2IP register/memory read path.
module fft_mag_frame_reader #(
  parameter int unsigned DATA_W    = 24,
  parameter int unsigned FRAME_LEN = 512,
  parameter int unsigned ADDR_W    = 9
) (
  input logic                  Bus2IP_Clk,
  input logic                  Bus2IP_Reset,
  fft_mag_frame_reader_if.slave bus
);

  localparam int unsigned CntW = ADDR_W + 1;
  localparam int unsigned SqW  = 2 * DATA_W;
  localparam logic [CntW-1:0] LastPtr = CntW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCapture = 2'd1,
    StDrain   = 2'd2,
    StDone    = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [CntW-1:0]   wr_ptr_q;
  logic [CntW-1:0]   bin_count_q;
  logic [15:0]       frame_count_q;
  logic              tlast_early_q, tlast_missing_q;
  logic              s1_valid_q, s2_valid_q;
  logic [SqW-1:0]    s1_re2_q, s1_im2_q;
  logic [ADDR_W-1:0] s1_addr_q, s2_addr_q;
  logic [31:0]       s2_mag_q;
  logic [31:0]       rdata_q;
  logic [31:0]       ram [FRAME_LEN];

  logic ctrl_wr, arm, abort, accept, at_last, frame_end;
  logic signed [SqW-1:0] re_ext, im_ext;
  logic [SqW:0]  mag_sum;
  logic [31:0]   mag_sat;
  logic [31:0]   rd_mux;
  logic          unused_data;

  assign unused_data = ^bus.Bus2IP_Data[31:2];

  assign bus.s_axis_data_tready = (state_q == StCapture);
  assign bus.frame_done         = (state_q == StDone);
  assign bus.mem_ip2bus_data    = rdata_q;

  assign ctrl_wr = bus.Bus2IP_WrCE & bus.mem_select & (bus.mem_address == ADDR_W'(0));
  assign abort   = ctrl_wr & bus.Bus2IP_Data[1];
  assign arm     = ctrl_wr & bus.Bus2IP_Data[0] & ~bus.Bus2IP_Data[1] &
                   ((state_q == StIdle) | (state_q == StDone));

  assign accept    = bus.s_axis_data_tvalid & bus.s_axis_data_tready;
  assign at_last   = (wr_ptr_q == LastPtr);
  assign frame_end = accept & (bus.s_axis_data_tlast | at_last);

  // Sign-extend before squaring so the product of the most negative value stays exact.
  assign re_ext  = {{DATA_W{bus.s_axis_data_tdata[DATA_W-1]}}, bus.s_axis_data_tdata[DATA_W-1:0]};
  assign im_ext  = {{DATA_W{bus.s_axis_data_tdata[SqW-1]}}, bus.s_axis_data_tdata[SqW-1:DATA_W]};
  assign mag_sum = {1'b0, s1_re2_q} + {1'b0, s1_im2_q};
  assign mag_sat = (|mag_sum[SqW:32]) ? 32'hFFFF_FFFF : mag_sum[31:0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StDone: if (arm) state_d = StCapture;
      StCapture:      if (frame_end) state_d = StDrain;
      StDrain:        if (!s1_valid_q && !s2_valid_q) state_d = StDone;
      default:        state_d = StIdle;
    endcase
    if (abort) state_d = StIdle;
  end

  always_comb begin
    rd_mux = 32'h0;
    if (bus.mem_select) begin
      if (bus.mem_address == ADDR_W'(0)) begin
        rd_mux = {26'b0, tlast_missing_q, tlast_early_q, 2'b0, state_q};
      end else if (bus.mem_address == ADDR_W'(1)) begin
        rd_mux = {{(32 - CntW){1'b0}}, bin_count_q};
      end else if (bus.mem_address == ADDR_W'(2)) begin
        rd_mux = {16'b0, frame_count_q};
      end
    end else if ({1'b0, bus.mem_address} < bin_count_q) begin
      rd_mux = ram[bus.mem_address];
    end
  end

  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset) begin
      state_q         <= StIdle;
      wr_ptr_q        <= '0;
      bin_count_q     <= '0;
      frame_count_q   <= '0;
      tlast_early_q   <= 1'b0;
      tlast_missing_q <= 1'b0;
      s1_valid_q      <= 1'b0;
      s2_valid_q      <= 1'b0;
      rdata_q         <= '0;
    end else begin
      state_q    <= state_d;
      s1_valid_q <= accept & ~abort;
      s2_valid_q <= s1_valid_q & ~abort;
      // Tracks the highest bin actually written, so an aborted frame stays readable.
      if (s2_valid_q) bin_count_q <= {1'b0, s2_addr_q} + CntW'(1);
      if (arm) begin
        wr_ptr_q        <= '0;
        tlast_early_q   <= 1'b0;
        tlast_missing_q <= 1'b0;
      end else if (accept) begin
        wr_ptr_q <= wr_ptr_q + CntW'(1);
        if (bus.s_axis_data_tlast && !at_last) tlast_early_q <= 1'b1;
        if (!bus.s_axis_data_tlast && at_last) tlast_missing_q <= 1'b1;
      end
      if (state_q == StDrain && state_d == StDone) frame_count_q <= frame_count_q + 16'd1;
      if (bus.mem_read_enable) rdata_q <= rd_mux;
    end
  end

  always_ff @(posedge Bus2IP_Clk) begin
    if (accept) begin
      s1_re2_q  <= re_ext * re_ext;
      s1_im2_q  <= im_ext * im_ext;
      s1_addr_q <= wr_ptr_q[ADDR_W-1:0];
    end
    if (s1_valid_q) begin
      s2_mag_q  <= mag_sat;
      s2_addr_q <= s1_addr_q;
    end
    if (s2_valid_q) ram[s2_addr_q] <= s2_mag_q;
  end

endmodule

// File: tb/tb_fft_mag_frame_reader.sv
// Randomised frame capture bench for fft_mag_frame_reader against a plain-arithmetic
// model of bin magnitudes, counters and status flags.
module tb_fft_mag_frame_reader;
  localparam int DATA_W    = 24;
  localparam int FRAME_LEN = 512;
  localparam int ADDR_W    = 9;

  logic Bus2IP_Clk   = 1'b0;
  logic Bus2IP_Reset = 1'b1;
  always #5 Bus2IP_Clk = ~Bus2IP_Clk;

  fft_mag_frame_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  fft_mag_frame_reader #(
    .DATA_W   (DATA_W),
    .FRAME_LEN(FRAME_LEN),
    .ADDR_W   (ADDR_W)
  ) dut (
    .Bus2IP_Clk  (Bus2IP_Clk),
    .Bus2IP_Reset(Bus2IP_Reset),
    .bus         (bus)
  );

  int     n_checks = 0;
  int     n_pass   = 0;
  int     re_a [FRAME_LEN];
  int     im_a [FRAME_LEN];
  longint exp_mem [FRAME_LEN];
  int     exp_frames = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic longint mag(input int re, input int im);
    longint p;
    p = longint'(re) * longint'(re) + longint'(im) * longint'(im);
    return (p > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : p;
  endfunction

  function automatic logic [47:0] pack(input int re, input int im);
    logic [23:0] r, m;
    r = re[23:0];
    m = im[23:0];
    return {m, r};
  endfunction

  function automatic int rand24();
    int v;
    v = $urandom;
    return v >>> 8;
  endfunction

  task automatic fill_random();
    for (int k = 0; k < FRAME_LEN; k++) begin
      re_a[k] = rand24();
      im_a[k] = rand24();
    end
  endtask

  task automatic ctrl_wr(input logic [31:0] d);
    bus.mem_select  = 1'b1;
    bus.mem_address = '0;
    bus.Bus2IP_Data = d;
    bus.Bus2IP_WrCE = 1'b1;
    @(negedge Bus2IP_Clk);
    bus.Bus2IP_WrCE = 1'b0;
  endtask

  task automatic rd(input logic sel, input int addr, output logic [31:0] d);
    bus.mem_select      = sel;
    bus.mem_address     = ADDR_W'(addr);
    bus.mem_read_enable = 1'b1;
    @(negedge Bus2IP_Clk);
    bus.mem_read_enable = 1'b0;
    d = bus.mem_ip2bus_data;
  endtask

  // Offers beats 0..n-1; returns cycles from last handshake to frame_done when end_chk is set.
  task automatic stream(input int n, input int last_idx, input int gap_pct, input bit end_chk,
                        output int lat);
    int i   = 0;
    int cyc = 0;
    lat = -1;
    while (i < n && cyc < 5000) begin
      if (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct) begin
        bus.s_axis_data_tvalid = 1'b0;
      end else begin
        bus.s_axis_data_tvalid = 1'b1;
        bus.s_axis_data_tdata  = pack(re_a[i], im_a[i]);
        bus.s_axis_data_tlast  = (i == last_idx);
      end
      if (bus.s_axis_data_tvalid && bus.s_axis_data_tready) begin
        exp_mem[i] = mag(re_a[i], im_a[i]);
        i++;
      end
      @(negedge Bus2IP_Clk);
      cyc++;
    end
    check("stream_beats", i, n);
    bus.s_axis_data_tlast = 1'b0;
    if (end_chk) begin
      bus.s_axis_data_tvalid = 1'b1;
      bus.s_axis_data_tdata  = pack(rand24(), rand24());
      check("post_frame_tready", bus.s_axis_data_tready, 0);
      lat = 0;
      while (!bus.frame_done && lat < 20) begin
        @(negedge Bus2IP_Clk);
        bus.s_axis_data_tvalid = 1'b0;
        lat++;
      end
    end
    bus.s_axis_data_tvalid = 1'b0;
  endtask

  task automatic check_frame(input int n, input logic [31:0] status_exp);
    logic [31:0] d;
    int idx;
    rd(1'b1, 0, d); check("status", d, status_exp);
    rd(1'b1, 1, d); check("bin_count", d, n);
    rd(1'b1, 2, d); check("frame_count", d, exp_frames);
    check("frame_done", bus.frame_done, 1);
    for (int k = 0; k < 6; k++) begin
      idx = (k == 0) ? n - 1 : int'($urandom_range(0, n - 1));
      rd(1'b0, idx, d);
      check("bin_value", d, exp_mem[idx]);
    end
  endtask

  initial begin
    logic [31:0] d;
    int lat;
    bus.s_axis_data_tdata  = '0;
    bus.s_axis_data_tvalid = 1'b0;
    bus.s_axis_data_tlast  = 1'b0;
    bus.Bus2IP_Data        = '0;
    bus.Bus2IP_WrCE        = 1'b0;
    bus.mem_select         = 1'b0;
    bus.mem_address        = '0;
    bus.mem_read_enable    = 1'b0;
    repeat (3) @(negedge Bus2IP_Clk);
    Bus2IP_Reset = 1'b0;

    // Idle after reset: stream is refused
    check("reset_rdata", bus.mem_ip2bus_data, 0);
    bus.s_axis_data_tvalid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge Bus2IP_Clk);
      check("idle_tready", bus.s_axis_data_tready, 0);
    end
    bus.s_axis_data_tvalid = 1'b0;
    rd(1'b1, 0, d); check("idle_status", d, 0);
    check("idle_frame_done", bus.frame_done, 0);

    // Ramp frame, tlast on the final bin
    for (int k = 0; k < FRAME_LEN; k++) begin
      re_a[k] = k;
      im_a[k] = 0;
    end
    ctrl_wr(32'h1);
    stream(FRAME_LEN, FRAME_LEN - 1, 0, 1'b1, lat);
    check("done_latency", lat, 3);
    exp_frames++;
    check_frame(FRAME_LEN, 32'h3);
    rd(1'b0, 7, d);   check("ramp_bin7", d, 49);
    rd(1'b0, 511, d); check("ramp_bin511", d, 261121);

    // Arithmetic corners, short frame
    re_a[0] = -3;       im_a[0] = 4;
    re_a[1] = 8388607;  im_a[1] = 8388607;
    re_a[2] = -8388608; im_a[2] = 0;
    re_a[3] = 256;      im_a[3] = -256;
    ctrl_wr(32'h1);
    stream(4, 3, 0, 1'b1, lat);
    exp_frames++;
    check("done_latency", lat, 3);
    rd(1'b0, 0, d); check("arith_3_4", d, 25);
    rd(1'b0, 1, d); check("arith_max", d, 32'hFFFF_FFFF);
    rd(1'b0, 2, d); check("arith_minneg", d, 32'hFFFF_FFFF);
    rd(1'b0, 3, d); check("arith_mixed", d, 32'h2_0000);
    rd(1'b1, 0, d); check("arith_status", d, 32'h13);

    // Early tlast with random tvalid gaps
    fill_random();
    ctrl_wr(32'h1);
    stream(100, 99, 30, 1'b1, lat);
    exp_frames++;
    check("done_latency", lat, 3);
    check_frame(100, 32'h13);
    rd(1'b0, 150, d); check("beyond_count", d, 0);

    // Missing tlast, tvalid held high
    fill_random();
    ctrl_wr(32'h1);
    stream(FRAME_LEN, -1, 0, 1'b1, lat);
    exp_frames++;
    check("done_latency", lat, 3);
    check_frame(FRAME_LEN, 32'h23);

    // Abort mid-frame
    fill_random();
    ctrl_wr(32'h1);
    stream(50, -1, 0, 1'b0, lat);
    ctrl_wr(32'h3);
    check("abort_tready", bus.s_axis_data_tready, 0);
    rd(1'b1, 0, d); check("abort_status", d, 0);
    rd(1'b1, 1, d); check("abort_bins_le_50", (d <= 50) ? 1 : 0, 1);
    rd(1'b1, 2, d); check("abort_frame_count", d, exp_frames);

    // Re-arm and capture a full frame
    fill_random();
    ctrl_wr(32'h1);
    stream(FRAME_LEN, FRAME_LEN - 1, 20, 1'b1, lat);
    exp_frames++;
    check("done_latency", lat, 3);
    check_frame(FRAME_LEN, 32'h3);

    // Reset mid-frame
    fill_random();
    ctrl_wr(32'h1);
    stream(20, -1, 0, 1'b0, lat);
    Bus2IP_Reset = 1'b1;
    bus.s_axis_data_tvalid = 1'b1;
    @(negedge Bus2IP_Clk);
    Bus2IP_Reset = 1'b0;
    check("rst_tready", bus.s_axis_data_tready, 0);
    check("rst_frame_done", bus.frame_done, 0);
    check("rst_rdata", bus.mem_ip2bus_data, 0);
    @(negedge Bus2IP_Clk);
    check("rst_tready_hold", bus.s_axis_data_tready, 0);
    bus.s_axis_data_tvalid = 1'b0;
    exp_frames = 0;
    rd(1'b1, 0, d); check("rst_status", d, 0);
    rd(1'b1, 1, d); check("rst_bin_count", d, 0);
    rd(1'b1, 2, d); check("rst_frame_count", d, exp_frames);
    rd(1'b0, 0, d); check("rst_bin0", d, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
